// File: rtl/mem_bist_pkg.sv
// Shared types and LFSR tap table for the memory BIST engine.
package mem_bist_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      WAIT = 3'd3,
      CHK  = 3'd4,
      DONE = 3'd5
   } bist_state_e;

   typedef enum logic [2:0] {
      CLR_W = 3'd0,
      CLR_R = 3'd1,
      ADR_W = 3'd2,
      ADR_R = 3'd3,
      RND   = 3'd4
   } bist_phase_e;

   // Toggle masks for a right-shifting Galois LFSR; unsupported widths give 0.
   function automatic logic [31:0] lfsr_taps(input int width);
      logic [31:0] taps;
      case (width)
         4:       taps = 32'h0000_000C;
         5:       taps = 32'h0000_0014;
         6:       taps = 32'h0000_0030;
         7:       taps = 32'h0000_0060;
         8:       taps = 32'h0000_00B8;
         9:       taps = 32'h0000_0110;
         10:      taps = 32'h0000_0240;
         11:      taps = 32'h0000_0500;
         12:      taps = 32'h0000_0829;
         13:      taps = 32'h0000_100D;
         14:      taps = 32'h0000_2015;
         15:      taps = 32'h0000_6000;
         16:      taps = 32'h0000_D008;
         17:      taps = 32'h0001_2000;
         18:      taps = 32'h0002_0400;
         19:      taps = 32'h0004_0023;
         20:      taps = 32'h0009_0000;
         21:      taps = 32'h0014_0000;
         22:      taps = 32'h0030_0000;
         23:      taps = 32'h0042_0000;
         24:      taps = 32'h00E1_0000;
         25:      taps = 32'h0120_0000;
         26:      taps = 32'h0200_0023;
         27:      taps = 32'h0400_0013;
         28:      taps = 32'h0900_0000;
         29:      taps = 32'h1400_0000;
         30:      taps = 32'h2000_0029;
         31:      taps = 32'h4800_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/mem_bist_lfsr.sv
// Galois LFSR supplying pseudo-random BIST data; a zero SEED is replaced by 1.
module mem_bist_lfsr
   import mem_bist_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              adv,
   output logic [DATA_W-1:0] q
);

   localparam logic [31:0]       TAPS_FULL = lfsr_taps(DATA_W);
   localparam logic [DATA_W-1:0] TAPS      = TAPS_FULL[DATA_W-1:0];
   localparam logic [DATA_W-1:0] SEED_NZ   = (SEED == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : SEED;

   logic [DATA_W-1:0] q_q;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         q_q <= SEED_NZ;
      end else if (adv) begin
         q_q <= {1'b0, q_q[DATA_W-1:1]} ^ (q_q[0] ? TAPS : '0);
      end else begin
         q_q <= q_q;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST engine: clear, data=address and (with MEM_BIST_RAND_EN) pseudo-random
// write/read-back phases, counting miscompares and capturing the first failing address.
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                DEPTH  = 32,
   parameter int                RD_LAT = 1,
   parameter int                ERR_W  = 8,
   parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5),
   localparam int               ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] err_addr,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
`ifdef MEM_BIST_RAND_EN
   localparam bit RAND_EN = 1'b1;
`else
   localparam bit RAND_EN = 1'b0;
`endif

   bist_state_e       state_q;
   bist_phase_e       phase_q;
   logic [ADDR_W-1:0] addr_q, err_addr_q, mem_addr_q, addr_inc_s;
   logic [WAIT_W-1:0] wait_q;
   logic [DATA_W-1:0] exp_q, mem_wdata_q, exp_s, addr_data_s, inc_data_s, lfsr_q;
   logic [ERR_W-1:0]  err_count_q, err_cnt_d;
   logic              busy_q, done_q, pass_q, mem_write_q, mem_read_q, mis_s, last_s;

`ifdef MEM_BIST_RAND_EN
   logic lfsr_load_s, lfsr_adv_s;
   assign lfsr_load_s = (state_q == IDLE) && start;
   assign lfsr_adv_s  = (state_q == WR) && (phase_q == RND);

   mem_bist_lfsr #(.DATA_W(DATA_W), .SEED(SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load_s),
      .adv  (lfsr_adv_s),
      .q    (lfsr_q)
   );
`else
   assign lfsr_q = '0;
`endif

   // Address-as-data is zero-extended or truncated to the word width.
   always_comb begin
      addr_inc_s  = addr_q + ADDR_W'(1);
      addr_data_s = '0;
      inc_data_s  = '0;
      for (int i = 0; i < DATA_W && i < ADDR_W; i++) begin
         addr_data_s[i] = addr_q[i];
         inc_data_s[i]  = addr_inc_s[i];
      end
      last_s = (addr_q == ADDR_W'(DEPTH - 1));
      case (phase_q)
         CLR_R:   exp_s = '0;
         ADR_R:   exp_s = addr_data_s;
         default: exp_s = exp_q;
      endcase
      mis_s     = (state_q == CHK) && (mem_rdata !== exp_s);
      err_cnt_d = err_count_q;
      if ((state_q == IDLE) && start) begin
         err_cnt_d = '0;
      end else if (mis_s && (err_count_q != '1)) begin
         err_cnt_d = err_count_q + ERR_W'(1'b1);
      end else begin
         err_cnt_d = err_count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         phase_q     <= CLR_W;
         addr_q      <= '0;
         wait_q      <= '0;
         exp_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         err_addr_q  <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         err_count_q <= err_cnt_d;
         if (mis_s && (err_count_q == '0)) err_addr_q <= addr_q;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  err_addr_q  <= '0;
                  pass_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= WR;
                  phase_q     <= CLR_W;
                  addr_q      <= '0;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end
            end
            WR: begin
               if (phase_q == RND) begin
                  exp_q      <= mem_wdata_q;
                  state_q    <= RD;
                  mem_read_q <= 1'b1;
               end else if (last_s) begin
                  phase_q    <= (phase_q == CLR_W) ? CLR_R : ADR_R;
                  addr_q     <= '0;
                  state_q    <= RD;
                  mem_read_q <= 1'b1;
                  mem_addr_q <= '0;
               end else begin
                  addr_q      <= addr_inc_s;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= addr_inc_s;
                  mem_wdata_q <= (phase_q == ADR_W) ? inc_data_s : '0;
               end
            end
            RD: begin
               wait_q  <= '0;
               state_q <= (RD_LAT == 1) ? CHK : WAIT;
            end
            WAIT: begin
               if (wait_q == WAIT_W'(RD_LAT - 2)) state_q <= CHK;
               wait_q <= wait_q + WAIT_W'(1'b1);
            end
            CHK: begin
               if (!last_s) begin
                  addr_q     <= addr_inc_s;
                  mem_addr_q <= addr_inc_s;
                  if (phase_q == RND) begin
                     state_q     <= WR;
                     mem_write_q <= 1'b1;
                     mem_wdata_q <= lfsr_q;
                  end else begin
                     state_q    <= RD;
                     mem_read_q <= 1'b1;
                  end
               end else if (phase_q == CLR_R) begin
                  phase_q     <= ADR_W;
                  addr_q      <= '0;
                  state_q     <= WR;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end else if ((phase_q == ADR_R) && RAND_EN) begin
                  phase_q     <= RND;
                  addr_q      <= '0;
                  state_q     <= WR;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= lfsr_q;
               end else begin
                  // Pass must already include a miscompare found in this final check.
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  pass_q      <= (err_cnt_d == '0);
                  addr_q      <= '0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign err_addr  = err_addr_q;
   assign mem_write = mem_write_q;
   assign mem_read  = mem_read_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench: two BIST instances (8-bit/RD_LAT=1 and 4-bit/RD_LAT=2) with
// behavioural memories, a memory-access scoreboard and a table of full runs.
module tb_mem_bist_ctrl;

   localparam int DEPTH = 32;
`ifdef MEM_BIST_RAND_EN
   localparam int NPH = 3;
`else
   localparam int NPH = 2;
`endif
   localparam int DONE_A = NPH * DEPTH * (1 + 2) + 1;
   localparam int DONE_B = NPH * DEPTH * (2 + 2) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       rst_v [2];
   logic       start_v [2];
   logic       busy_a, done_a, pass_a, mw_a, mr_a;
   logic [7:0] errc_a, wd_a, rd_a;
   logic [4:0] erra_a, ma_a;
   logic       busy_b, done_b, pass_b, mw_b, mr_b;
   logic [1:0] errc_b;
   logic [3:0] wd_b, rd_b, pipe_b;
   logic [4:0] erra_b, ma_b;

   mem_bist_ctrl u_dut_a (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_a), .done(done_a),
      .pass(pass_a), .err_count(errc_a), .err_addr(erra_a), .mem_write(mw_a),
      .mem_read(mr_a), .mem_addr(ma_a), .mem_wdata(wd_a), .mem_rdata(rd_a)
   );

   mem_bist_ctrl #(.DATA_W(4), .DEPTH(32), .RD_LAT(2), .ERR_W(2)) u_dut_b (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_b), .done(done_b),
      .pass(pass_b), .err_count(errc_b), .err_addr(erra_b), .mem_write(mw_b),
      .mem_read(mr_b), .mem_addr(ma_b), .mem_wdata(wd_b), .mem_rdata(rd_b)
   );

   logic [7:0] mem_a [DEPTH];
   logic [3:0] mem_b [DEPTH];
   bit         fault_a = 1'b0;
   bit         ones_b  = 1'b0;

   // Memory A: latency 1, optional address 5 bit 3 stuck at 1 on the read path.
   always @(posedge clk) begin
      if (mw_a) mem_a[ma_a] <= wd_a;
      if (mr_a) rd_a <= mem_a[ma_a] | ((fault_a && (ma_a == 5'd5)) ? 8'h08 : 8'h00);
   end

   // Memory B: latency 2, optional all-ones read data.
   always @(posedge clk) begin
      if (mw_b) mem_b[ma_b] <= wd_b;
      if (mr_b) pipe_b <= ones_b ? 4'hF : mem_b[ma_b];
      rd_b <= pipe_b;
   end

   int s_busy [2], s_done [2], s_pass [2], s_err [2], s_eaddr [2];
   int s_mw [2], s_mr [2], s_ma [2], s_wd [2];
   always_comb begin
      s_busy[0] = int'(busy_a);  s_busy[1] = int'(busy_b);
      s_done[0] = int'(done_a);  s_done[1] = int'(done_b);
      s_pass[0] = int'(pass_a);  s_pass[1] = int'(pass_b);
      s_err[0]  = int'(errc_a);  s_err[1]  = int'(errc_b);
      s_eaddr[0] = int'(erra_a); s_eaddr[1] = int'(erra_b);
      s_mw[0] = int'(mw_a);      s_mw[1] = int'(mw_b);
      s_mr[0] = int'(mr_a);      s_mr[1] = int'(mr_b);
      s_ma[0] = int'(ma_a);      s_ma[1] = int'(ma_b);
      s_wd[0] = int'(wd_a);      s_wd[1] = int'(wd_b);
   end

   typedef struct { bit wr; int addr; int data; } op_t;
   op_t q_a [$];
   op_t q_b [$];

   typedef struct {
      int unit; bit fault; int stray_at; int exp_done; int exp_pass; int exp_err; int exp_addr;
   } run_t;
   run_t tbl [5];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int lfsr_step(input int v, input int w);
      int taps;
      taps = (w == 8) ? 'hB8 : 'hC;
      return ((v & 1) != 0) ? ((v >> 1) ^ taps) : (v >> 1);
   endfunction

   task automatic push_op(input int u, input bit wr, input int a, input int d);
      op_t o;
      o = '{wr: wr, addr: a, data: d};
      if (u == 0) q_a.push_back(o);
      else        q_b.push_back(o);
   endtask

   // Expected memory access sequence of one complete run.
   task automatic push_run(input int u);
      int w, mask, lf;
      w    = (u == 0) ? 8 : 4;
      mask = (1 << w) - 1;
      lf   = 'hA5 & mask;
      for (int a = 0; a < DEPTH; a++) push_op(u, 1'b1, a, 0);
      for (int a = 0; a < DEPTH; a++) push_op(u, 1'b0, a, 0);
      for (int a = 0; a < DEPTH; a++) push_op(u, 1'b1, a, a & mask);
      for (int a = 0; a < DEPTH; a++) push_op(u, 1'b0, a, 0);
      for (int a = 0; a < DEPTH && NPH == 3; a++) begin
         push_op(u, 1'b1, a, lf);
         push_op(u, 1'b0, a, 0);
         lf = lfsr_step(lf, w);
      end
   endtask

   task automatic check_op(input int u, input int w, input int r, input int a, input int d);
      op_t e;
      checks++;
      if ((w != 0) && (r != 0)) begin
         errors++;
         $display("FAIL op_excl unit%0d: write and read both high at addr %0d", u, a);
      end else if ((u == 0 && q_a.size() == 0) || (u == 1 && q_b.size() == 0)) begin
         errors++;
         $display("FAIL op_extra unit%0d: got wr=%0d addr %0d data %0d, expected no access", u, w, a, d);
      end else begin
         if (u == 0) e = q_a.pop_front();
         else        e = q_b.pop_front();
         if ((int'(e.wr) != w) || (e.addr != a) || ((w != 0) && (e.data != d))) begin
            errors++;
            $display("FAIL op_seq unit%0d: got wr=%0d addr %0d data %0d, expected wr=%0d addr %0d data %0d",
                     u, w, a, d, e.wr, e.addr, e.data);
         end
      end
   endtask

   // Scoreboard: every DUT memory access is popped against the model sequence.
   always @(negedge clk) begin
      if (mw_a || mr_a) check_op(0, s_mw[0], s_mr[0], s_ma[0], s_wd[0]);
      if (mw_b || mr_b) check_op(1, s_mw[1], s_mr[1], s_ma[1], s_wd[1]);
   end

   task automatic chk_idle(input string nm, input int u);
      chk($sformatf("%s_u%0d_busy", nm, u), s_busy[u], 0);
      chk($sformatf("%s_u%0d_done", nm, u), s_done[u], 0);
      chk($sformatf("%s_u%0d_pass", nm, u), s_pass[u], 0);
      chk($sformatf("%s_u%0d_err", nm, u), s_err[u], 0);
      chk($sformatf("%s_u%0d_eaddr", nm, u), s_eaddr[u], 0);
      chk($sformatf("%s_u%0d_mw", nm, u), s_mw[u], 0);
      chk($sformatf("%s_u%0d_mr", nm, u), s_mr[u], 0);
      chk($sformatf("%s_u%0d_maddr", nm, u), s_ma[u], 0);
      chk($sformatf("%s_u%0d_wdata", nm, u), s_wd[u], 0);
   endtask

   task automatic do_run(input int idx, input run_t t);
      int n, done_at, u, qs;
      u = t.unit;
      if (u == 0) fault_a = t.fault;
      else        ones_b  = t.fault;
      @(negedge clk);
      push_run(u);
      start_v[u] = 1'b1;
      n = 0;
      done_at = -1;
      while (done_at < 0 && n < t.exp_done + 50) begin
         @(negedge clk);
         n++;
         start_v[u] = (n == t.stray_at);
         if (n == 1) chk($sformatf("run%0d_busy_c1", idx), s_busy[u], 1);
         if (s_done[u] != 0) done_at = n;
      end
      start_v[u] = 1'b0;
      qs = (u == 0) ? q_a.size() : q_b.size();
      chk($sformatf("run%0d_done_cycle", idx), done_at, t.exp_done);
      chk($sformatf("run%0d_pass", idx), s_pass[u], t.exp_pass);
      chk($sformatf("run%0d_err_count", idx), s_err[u], t.exp_err);
      chk($sformatf("run%0d_err_addr", idx), s_eaddr[u], t.exp_addr);
      chk($sformatf("run%0d_busy_at_done", idx), s_busy[u], 0);
      chk($sformatf("run%0d_mr_at_done", idx), s_mr[u], 0);
      chk($sformatf("run%0d_mw_at_done", idx), s_mw[u], 0);
      chk($sformatf("run%0d_ops_left", idx), qs, 0);
      @(negedge clk);
      chk($sformatf("run%0d_done_pulse", idx), s_done[u], 0);
      chk($sformatf("run%0d_pass_hold", idx), s_pass[u], t.exp_pass);
      chk($sformatf("run%0d_err_hold", idx), s_err[u], t.exp_err);
      if (u == 0) q_a.delete();
      else        q_b.delete();
   endtask

   initial begin
      int n, done_seen;
      tbl[0] = '{0, 1'b0, -1, DONE_A, 1, 0, 0};
      tbl[1] = '{0, 1'b1, -1, DONE_A, 0, 2, 5};
      tbl[2] = '{0, 1'b0, 50, DONE_A, 1, 0, 0};
      tbl[3] = '{1, 1'b0, -1, DONE_B, 1, 0, 0};
      tbl[4] = '{1, 1'b1, -1, DONE_B, 0, 3, 0};

      rst_v[0] = 1'b1;   rst_v[1] = 1'b1;
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle("reset", 0);
      chk_idle("reset", 1);
      rst_v[0] = 1'b0;   rst_v[1] = 1'b0;

      for (int i = 0; i < 5; i++) do_run(i, tbl[i]);

      // Reset and start together: reset wins, nothing starts.
      fault_a = 1'b0;
      @(negedge clk);
      rst_v[0] = 1'b1; start_v[0] = 1'b1;
      @(negedge clk);
      chk("rst_start_busy", s_busy[0], 0);
      chk("rst_start_mw", s_mw[0], 0);
      rst_v[0] = 1'b0; start_v[0] = 1'b0;
      @(negedge clk);
      chk("rst_start_idle", s_busy[0], 0);

      // Reset in mid-run aborts with no done pulse.
      push_run(0);
      start_v[0] = 1'b1;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         start_v[0] = 1'b0;
      end
      chk("abort_busy_before", s_busy[0], 1);
      rst_v[0] = 1'b1;
      @(negedge clk);
      chk_idle("abort", 0);
      rst_v[0] = 1'b0;
      q_a.delete();
      done_seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (s_done[0] != 0) done_seen = 1;
      end
      chk("abort_no_done", done_seen, 0);

      do_run(5, tbl[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
